mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one memory command channel between an
// instruction-fetch port and a data port. Only one command is outstanding at a time.
// Data has priority, but the fetch port gets a grant after MAX_D_STREAK data
// grants in a row while it is waiting.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MAX_D_STREAK = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  // instruction fetch port
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ready,
  // data port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  // memory command channel
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_done
);

  localparam int unsigned STREAK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE_I = 3'd1;
  localparam logic [2:0] S_ISSUE_D = 3'd2;
  localparam logic [2:0] S_WAIT_I  = 3'd3;
  localparam logic [2:0] S_WAIT_D  = 3'd4;

  logic [2:0]            state_q,     state_d;
  logic [STREAK_W-1:0]   d_streak_q,  d_streak_d;
  logic                  mem_en_q,    mem_en_d;
  logic                  mem_we_q,    mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] i_rdata_q,   i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q,   d_rdata_d;
  logic                  i_ready_q,   i_ready_d;
  logic                  d_ready_q,   d_ready_d;

  // Next-state and registered-output logic; the command is latched at grant so
  // mem_en is high for exactly the ISSUE cycle.
  always_comb begin
    state_d     = state_q;
    d_streak_d  = d_streak_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Requests are still asserted during the ready pulse; no grant that cycle.
        if (!i_ready_q && !d_ready_q) begin
          if (d_req && (!i_req || (d_streak_q != STREAK_MAX))) begin
            state_d     = S_ISSUE_D;
            mem_en_d    = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            if (!i_req) begin
              d_streak_d = '0;
            end else if (d_streak_q != STREAK_MAX) begin
              d_streak_d = d_streak_q + STREAK_W'(1);
            end
          end else if (i_req) begin
            state_d     = S_ISSUE_I;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
            d_streak_d  = '0;
          end
        end
      end
      S_ISSUE_I: state_d = S_WAIT_I;
      S_ISSUE_D: state_d = S_WAIT_D;
      S_WAIT_I: begin
        if (mem_done) begin
          i_rdata_d = mem_rdata;
          i_ready_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WAIT_D: begin
        if (mem_done) begin
          // Stores complete without touching the load data register.
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
          d_ready_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      d_streak_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_streak_q  <= d_streak_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;

endmodule
